// File: rtl/out_port_arbiter_pkg.sv
// Shared types and helpers for the output-port arbiter: packet layout, FSM states, byte select.
package out_port_arbiter_pkg;

  localparam int unsigned PKT_BYTES = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = $clog2(PKT_BYTES);

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  // Wire order: header byte first, then data most-significant byte first.
  function automatic logic [BYTE_W-1:0] pkt_byte(input pkt_t p, input logic [CNT_W-1:0] k);
    logic [BYTE_W-1:0] b;
    case (k)
      2'd0:    b = {p.src, p.dest};
      2'd1:    b = p.data[23:16];
      2'd2:    b = p.data[15:8];
      default: b = p.data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester at or after i_rr_ptr, modulo NUM_IN.
module rr_picker #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned ID_W   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [ID_W-1:0]   i_rr_ptr,
  output logic              o_found_c,
  output logic [ID_W-1:0]   o_winner_c
);

  localparam int unsigned SUM_W = ID_W + 1;
  localparam logic [SUM_W-1:0] NUM_IN_W = SUM_W'(NUM_IN);

  logic [SUM_W-1:0] w_sum;

  // Scan highest offset first so the nearest requester is the last one written.
  always_comb begin
    o_found_c  = 1'b0;
    o_winner_c = '0;
    w_sum      = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_rr_ptr} + SUM_W'(k);
      if (w_sum >= NUM_IN_W) w_sum = w_sum - NUM_IN_W;
      if (i_req[ID_W'(w_sum)]) begin
        o_found_c  = 1'b1;
        o_winner_c = ID_W'(w_sum);
      end
    end
  end

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter for one router output port; latches the winning packet and
// sends it as four byte transfers on the free/put/payload handshake.
module out_port_arbiter
  import out_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned ID_W   = $clog2(NUM_IN)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_IN-1:0]   req,
  input  pkt_t                pkt_in [NUM_IN],
  output logic [NUM_IN-1:0]   ack,
  input  logic                free_outbound,
  output logic                put_outbound,
  output logic [BYTE_W-1:0]   payload_outbound,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id
);

  arb_state_t          r_state,    w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr,   w_rr_ptr_nxt;
  logic [CNT_W-1:0]    r_byte_cnt, w_byte_cnt_nxt;
  pkt_t                r_pkt,      w_pkt_nxt;
  logic                r_put,      w_put_nxt;
  logic [BYTE_W-1:0]   r_payload,  w_payload_nxt;
  logic [NUM_IN-1:0]   r_ack,      w_ack_nxt;
  logic                r_busy,     w_busy_nxt;
  logic [ID_W-1:0]     r_grant_id, w_grant_id_nxt;

  logic                w_found;
  logic [ID_W-1:0]     w_winner;

  rr_picker #(
    .NUM_IN (NUM_IN),
    .ID_W   (ID_W)
  ) u_rr_picker (
    .i_req      (req),
    .i_rr_ptr   (r_rr_ptr),
    .o_found_c  (w_found),
    .o_winner_c (w_winner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_pkt      <= '0;
      r_put      <= 1'b0;
      r_payload  <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_pkt      <= w_pkt_nxt;
      r_put      <= w_put_nxt;
      r_payload  <= w_payload_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= w_busy_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  // put and ack are single-edge pulses by default; everything else holds.
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_byte_cnt_nxt = r_byte_cnt;
    w_pkt_nxt      = r_pkt;
    w_put_nxt      = 1'b0;
    w_payload_nxt  = r_payload;
    w_ack_nxt      = '0;
    w_busy_nxt     = r_busy;
    w_grant_id_nxt = r_grant_id;

    case (r_state)
      IDLE: begin
        if (w_found && free_outbound) begin
          w_pkt_nxt      = pkt_in[w_winner];
          w_grant_id_nxt = w_winner;
          w_ack_nxt      = NUM_IN'(1) << w_winner;
          w_byte_cnt_nxt = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        w_put_nxt      = 1'b1;
        w_payload_nxt  = pkt_byte(r_pkt, r_byte_cnt);
        w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
        if (r_byte_cnt == CNT_W'(PKT_BYTES - 1)) begin
          w_state_nxt  = IDLE;
          w_busy_nxt   = 1'b0;
          w_rr_ptr_nxt = (r_grant_id == ID_W'(NUM_IN - 1)) ? '0 : r_grant_id + ID_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ack              = r_ack;
  assign put_outbound     = r_put;
  assign payload_outbound = r_payload;
  assign busy             = r_busy;
  assign grant_id         = r_grant_id;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: a 4-input instance and a 3-input instance for the wrap case.
module tb_out_port_arbiter;
  import out_port_arbiter_pkg::*;

  logic        clk;
  logic        reset_n;

  logic [3:0]  req;
  pkt_t        pkt_in [4];
  logic [3:0]  ack;
  logic        free;
  logic        put;
  logic [7:0]  payload;
  logic        busy;
  logic [1:0]  grant_id;

  logic [2:0]  req3;
  pkt_t        pkt3 [3];
  logic [2:0]  ack3;
  logic        free3;
  logic        put3;
  logic [7:0]  payload3;
  logic        busy3;
  logic [1:0]  grant3;

  int n_vec;
  int n_mis;

  logic [31:0] P  [4] = '{32'h0F_102030, 32'h1E_405060, 32'h3A_123456, 32'hC5_ABCDEF};
  logic [31:0] P3 [3] = '{32'h21_000102, 32'h22_030405, 32'h23_060708};

  out_port_arbiter #(.NUM_IN(4)) u_dut (
    .clock            (clk),
    .reset_n          (reset_n),
    .req              (req),
    .pkt_in           (pkt_in),
    .ack              (ack),
    .free_outbound    (free),
    .put_outbound     (put),
    .payload_outbound (payload),
    .busy             (busy),
    .grant_id         (grant_id)
  );

  out_port_arbiter #(.NUM_IN(3)) u_dut3 (
    .clock            (clk),
    .reset_n          (reset_n),
    .req              (req3),
    .pkt_in           (pkt3),
    .ack              (ack3),
    .free_outbound    (free3),
    .put_outbound     (put3),
    .payload_outbound (payload3),
    .busy             (busy3),
    .grant_id         (grant3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic byte_step(input logic [7:0] exp_byte, input logic exp_busy);
    tick();
    chk("put_hi", 32'(put), 32'd1);
    chk("payload", 32'(payload), 32'(exp_byte));
    chk("ack_lo", 32'(ack), 32'd0);
    chk("busy_send", 32'(busy), 32'(exp_busy));
  endtask

  // Arbitration edge, then the four byte edges; req is replaced by keep_req after the ack.
  task automatic grant_and_send(input int id, input logic [31:0] p, input logic [3:0] keep_req);
    tick();
    chk("ack_onehot", 32'(ack), 32'(1) << id);
    chk("grant_id", 32'(grant_id), 32'(id));
    chk("busy_arb", 32'(busy), 32'd1);
    chk("put_gap", 32'(put), 32'd0);
    req = keep_req;
    for (int k = 0; k < 4; k++) byte_step(p[31 - 8*k -: 8], k < 3);
  endtask

  initial begin
    n_vec   = 0;
    n_mis   = 0;
    reset_n = 1'b1;
    req     = '0;
    free    = 1'b0;
    req3    = '0;
    free3   = 1'b0;
    for (int i = 0; i < 4; i++) pkt_in[i] = pkt_t'(P[i]);
    for (int i = 0; i < 3; i++) pkt3[i]   = pkt_t'(P3[i]);

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_put", 32'(put), 32'd0);
    chk("rst_payload", 32'(payload), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Single request from input 2
    req  = 4'b0100;
    free = 1'b1;
    grant_and_send(2, P[2], 4'b0000);

    // Backpressure: no grant while free is low
    req  = 4'b0001;
    free = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_ack", 32'(ack), 32'd0);
      chk("bp_put", 32'(put), 32'd0);
    end
    free = 1'b1;
    grant_and_send(0, P[0], 4'b0000);

    // Mid-packet free drop and req[1] drop; rr_ptr is now 1
    req = 4'b1000;
    tick();
    chk("mid_ack", 32'(ack), 32'b1000);
    chk("mid_grant", 32'(grant_id), 32'd3);
    req = 4'b0110;
    byte_step(8'hC5, 1'b1);
    free = 1'b0;
    byte_step(8'hAB, 1'b1);
    req = 4'b0100;
    byte_step(8'hCD, 1'b1);
    byte_step(8'hEF, 1'b0);
    tick();
    chk("mid_nofree_ack", 32'(ack), 32'd0);
    chk("mid_nofree_put", 32'(put), 32'd0);
    free = 1'b1;
    grant_and_send(2, P[2], 4'b0000);

    // Reset mid-packet, after byte1
    req = 4'b0100;
    tick();
    chk("pre_rst_ack", 32'(ack), 32'b0100);
    req = 4'b0000;
    byte_step(8'h3A, 1'b1);
    byte_step(8'h12, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_put", 32'(put), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_grant", 32'(grant_id), 32'd0);
    #2 reset_n = 1'b1;
    req = 4'b1010;
    grant_and_send(1, P[1], 4'b1111);

    // All requesting, rr_ptr=2 after the grant to input 1
    grant_and_send(2, P[2], 4'b1111);
    grant_and_send(3, P[3], 4'b1111);
    grant_and_send(0, P[0], 4'b1111);
    grant_and_send(1, P[1], 4'b1111);
    grant_and_send(2, P[2], 4'b0000);
    tick();
    chk("idle_put", 32'(put), 32'd0);
    chk("idle_ack", 32'(ack), 32'd0);

    // NUM_IN=3 wrap: grants 0,1,2,0
    req3  = 3'b111;
    free3 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int id;
      logic [31:0] p;
      id = (g == 3) ? 0 : g;
      p  = P3[id];
      tick();
      chk("w3_ack", 32'(ack3), 32'(1) << id);
      chk("w3_grant", 32'(grant3), 32'(id));
      chk("w3_gap", 32'(put3), 32'd0);
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("w3_put", 32'(put3), 32'd1);
        chk("w3_payload", 32'(payload3), 32'(p[31 - 8*k -: 8]));
      end
    end
    req3 = 3'b000;
    tick();
    chk("w3_idle_busy", 32'(busy3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/out_port_arbiter.md
Name: out_port_arbiter

Overview:
Round-robin arbiter and serializer for one router output port. NUM_IN input buffers each present a full 32-bit packet with a request. The arbiter grants one requester, latches its packet, and drives it downstream as 4 byte-serial transfers on the free/put/payload handshake used between nodes and routers. It sits in the router, one instance per output port, ahead of the neighbour router or destination node.

Parameters:
NUM_IN, 4, number of requesting input buffers (legal range 2..8)
ID_W, $clog2(NUM_IN), width of the granted-input index

Ports:
clock  input  1  system clock, all state on posedge
reset_n  input  1  asynchronous active-low reset
req  input  NUM_IN  req[i]=1: input i holds a packet for this port
pkt_in  input  NUM_IN x 32 (pkt_t array)  packet held by each input, valid while req[i]=1
ack  output  NUM_IN  one-cycle one-hot pulse; input i must dequeue its packet on this edge
free_outbound  input  1  downstream can accept a new packet
put_outbound  output  1  byte valid on payload_outbound
payload_outbound  output  8  packet byte to downstream
busy  output  1  packet in flight (state SEND)
grant_id  output  ID_W  index of the last granted input

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, byte_cnt=0, put_outbound=0, payload_outbound=0, ack=0, busy=0, grant_id=0, packet register=0. Takes effect immediately, including mid-packet. The partial packet is dropped and no further bytes are sent.
- All outputs are registered.
- States are IDLE and SEND.
- IDLE, edge with |req && free_outbound:
  - Pick winner w = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_IN.
  - Latch pkt_in[w], set grant_id<=w, ack<=onehot(w), byte_cnt<=0, busy<=1, state<=SEND, put_outbound<=0.
- IDLE otherwise: put_outbound<=0, ack<=0. req is ignored while free_outbound=0.
- SEND: on each edge put_outbound<=1 and payload_outbound<=byte[byte_cnt], with byte_cnt++. ack<=0 after its single cycle.
  - byte0={src,dest}, byte1=data[23:16], byte2=data[15:8], byte3=data[7:0].
  - On the edge emitting byte3: state<=IDLE, busy<=0, rr_ptr<=(w+1) mod NUM_IN.
- Latency: arbitration edge E0 → ack high in the cycle after E0. put_outbound is high for exactly 4 consecutive cycles, after edges E1..E4.
- free_outbound and req are not sampled during SEND. A packet is never stalled once started.
- Back-to-back packets: the earliest re-arbitration is at E5, which drives put_outbound=0. This guarantees at least one put-low cycle between packets, so downstream can detect packet end.
- rr_ptr wraps NUM_IN-1 → 0. For non-power-of-2 NUM_IN, rr_ptr never takes values ≥ NUM_IN.
- A req deasserted before the arbitration edge is not granted; no ack is produced for it.
- The same input may win consecutively only if it is the sole requester.
- ack is only ever asserted for a requester whose req was 1 at the arbitration edge.

Decomposition:
- RouterPkg gets:
  - PKT_BYTES=4
  - the state enum arb_state_t {IDLE, SEND}
  - a byte-select function that returns byte k of a pkt_t
- pkt_t is reused from RouterPkg.
- One combinational sub-module, rr_picker (inputs req, rr_ptr; outputs found, winner index), instantiated once.

Test Plan:
- Single request: req=4'b0100, pkt_in[2]=32'h3A_123456, free=1 → ack=4'b0100 for 1 cycle; put high 4 cycles with bytes 3A,12,34,56; grant_id=2; busy low afterwards.
- All requesting: req=4'b1111 held, free held 1 → grant order 0,1,2,3,0; one put-low gap between packets.
- Backpressure: req=4'b0001 with free=0 for 10 cycles → no ack, put=0. Raise free → transfer starts on the next edge.
- Mid-packet free drop and req drop: free falls after byte0 and req[1] falls during SEND → all 4 bytes are still sent; input 1 is not granted on the next arbitration.
- Reset mid-packet: assert reset_n=0 after byte1 → put_outbound and busy go 0 immediately, without waiting for a clock. After release with req=4'b0010 → grant goes to input 1, since rr_ptr was reset to 0.
- NUM_IN=3 wrap: req=3'b111 → grants 0,1,2,0; rr_ptr never reaches 3.
